// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit layout.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 5;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic [4:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY]  = busy;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push is ignored when full and pop when empty, both judged
// on the occupancy before the edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA queue bytes in a
// FIFO, STATUS reports busy/full/empty/count, overflowing writes are counted.
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADR     = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        tx,
  output logic [7:0]  drop_cnt
);

  localparam int            TW     = $clog2(CLKS_PER_BIT);
  localparam int            CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  logic          adr_tx, adr_stat, wr_tx;
  logic          f_full, f_empty, pop;
  logic [CW-1:0] f_count;
  logic [7:0]    f_dout;
  logic          unused_wdata;

  tx_state_e     state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_q, tx_n;
  logic          bit_end;

  assign adr_tx       = (DataAdr == BASE_ADR + TXDATA_OFS);
  assign adr_stat     = (DataAdr == BASE_ADR + STATUS_OFS);
  assign wr_tx        = MemWrite & adr_tx;
  assign Hit          = adr_tx | adr_stat;
  assign ReadData     = adr_stat ? pack_status(state != IDLE, f_full, f_empty, 5'(f_count)) : '0;
  assign tx           = tx_q;
  assign unused_wdata = ^WriteData[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign bit_end = (timer == T_LAST);

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    pop     = 1'b0;
    if (state != IDLE) timer_n = bit_end ? '0 : timer + 1'b1;
    case (state)
      IDLE: begin
        tx_n    = 1'b1;
        timer_n = '0;
        if (!f_empty) begin
          pop     = 1'b1;
          shreg_n = f_dout;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        tx_n    = shreg[0];
      end
      // Shift register always presents the current bit at [0]; idx wraps 7->0.
      DATA: if (bit_end) begin
        shreg_n = {1'b0, shreg[7:1]};
        idx_n   = idx + 3'd1;
        if (idx == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          tx_n    = shreg[1];
        end
      end
      STOP: if (bit_end) begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      tx_q  <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                      drop_cnt <= '0;
    else if (wr_tx && f_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset, MemWrite;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic        Hit, tx;
  logic [7:0]  drop_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .BASE_ADR(32'h0000_0400)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .tx        (tx),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [31:0] adr;
    logic        hit;
    logic [31:0] rd;
  } dec_vec_t;

  dec_vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = adr; WriteData = d;
    tick();
    MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
  endtask

  task automatic status(output logic [31:0] v);
    DataAdr = 32'h404;
    #1;
    v = ReadData;
    DataAdr = 32'h0;
  endtask

  task automatic chk_status(input string nm, input logic [31:0] exp);
    logic [31:0] v;
    status(v);
    check(nm, v, exp);
  endtask

  // Wait for a start bit, then sample each bit in its middle.
  task automatic rx_byte(input string nm, input logic [7:0] exp);
    logic [7:0] b = 8'h00;
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (tx === 1'b0) begin found = 1'b1; break; end
    end
    check({nm, " start_seen"}, 32'(found), 32'd1);
    if (found) begin
      repeat (2) tick();
      for (int j = 0; j < 8; j++) begin
        repeat (4) tick();
        b[j] = tx;
      end
      repeat (4) tick();
      check({nm, " stop"}, 32'(tx), 32'd1);
      check(nm, 32'(b), 32'(exp));
    end
  endtask

  initial begin
    logic [7:0] byte55;
    int         lows;

    vecs[0] = '{32'h0000_0400, 1'b1, 32'h0};
    vecs[1] = '{32'h0000_0404, 1'b1, 32'h0000_0004};
    vecs[2] = '{32'h0000_0408, 1'b0, 32'h0};
    vecs[3] = '{32'h0000_03FC, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_0000, 1'b0, 32'h0};
    vecs[5] = '{32'h0000_1404, 1'b0, 32'h0};

    reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
    // Write during reset must not be queued.
    MemWrite = 1'b1; DataAdr = 32'h400; WriteData = 32'h99;
    tick(); tick();
    MemWrite = 1'b0; DataAdr = 32'h0;
    check("reset tx", 32'(tx), 32'd1);
    check("reset drop_cnt", 32'(drop_cnt), 32'd0);
    chk_status("reset status", 32'h0000_0004);
    reset = 1'b0;
    tick();

    foreach (vecs[k]) begin
      DataAdr = vecs[k].adr;
      #1;
      check($sformatf("hit[%0d]", k), 32'(Hit), 32'(vecs[k].hit));
      check($sformatf("rdata[%0d]", k), ReadData, vecs[k].rd);
    end
    DataAdr = 32'h0;
    check("idle tx after reset-write", 32'(tx), 32'd1);

    // Single 0x55 frame, cycle-exact.
    byte55 = 8'h55;
    wr(32'h400, 32'h55);
    check("latency tx before", 32'(tx), 32'd1);
    for (int k = 0; k < 40; k++) begin
      logic expb;
      tick();
      if (k < 4)       expb = 1'b0;
      else if (k < 36) expb = byte55[(k - 4) / 4];
      else             expb = 1'b1;
      check($sformatf("frame55 cyc%0d", k), 32'(tx), 32'(expb));
    end
    tick();
    check("frame55 end tx", 32'(tx), 32'd1);
    chk_status("frame55 status", 32'h0000_0004);

    // Burst of six writes into a depth-4 FIFO.
    fork
      begin
        for (int k = 1; k <= 6; k++) wr(32'h400, 32'(k));
        chk_status("burst status", 32'h0000_0403);
        check("burst drop_cnt", 32'(drop_cnt), 32'd1);
      end
      begin
        for (int k = 1; k <= 5; k++) rx_byte($sformatf("burst rx%0d", k), 8'(k));
      end
    join
    repeat (3) tick();
    chk_status("burst idle status", 32'h0000_0004);
    check("burst drop_cnt final", 32'(drop_cnt), 32'd1);

    // Reset in the middle of DATA bit 3 of 0x55 with one byte still queued.
    wr(32'h400, 32'h55);
    wr(32'h400, 32'h77);
    repeat (17) tick();
    check("mid bit3 tx", 32'(tx), 32'd0);
    chk_status("mid status", 32'h0000_0101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort tx", 32'(tx), 32'd1);
    chk_status("abort status", 32'h0000_0004);
    check("abort drop_cnt", 32'(drop_cnt), 32'd0);
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("abort no frames", 32'(lows), 32'd0);

    // Push on a pop edge, non-full then full.
    wr(32'h400, 32'hA1);
    wr(32'h400, 32'hA2);
    wr(32'h400, 32'hA3);
    repeat (39) tick();
    chk_status("pre pop cnt2", 32'h0000_0200);
    wr(32'h400, 32'hA4);
    chk_status("push+pop cnt2", 32'h0000_0201);
    wr(32'h400, 32'hA5);
    wr(32'h400, 32'hA6);
    repeat (38) tick();
    chk_status("pre pop full", 32'h0000_0402);
    wr(32'h400, 32'hA7);
    chk_status("full push+pop", 32'h0000_0301);
    check("full pop drop_cnt", 32'(drop_cnt), 32'd1);

    // Byte-lane and address filtering.
    reset = 1'b1; tick(); reset = 1'b0;
    fork
      begin
        wr(32'h400, 32'hDEAD_BEA5);
        wr(32'h400, 32'h0000_0011);
        wr(32'h404, 32'h0000_0022);
        wr(32'h408, 32'h0000_0033);
        chk_status("filter status", 32'h0000_0101);
      end
      begin
        rx_byte("filter rxA5", 8'hA5);
        rx_byte("filter rx11", 8'h11);
      end
    join
    repeat (3) tick();
    chk_status("filter idle", 32'h0000_0004);

    // Drop counter: exact count, then saturation.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 5; k++) wr(32'h400, 32'(k));
    for (int k = 0; k < 10; k++) wr(32'h400, 32'hEE);
    check("drop_cnt 10", 32'(drop_cnt), 32'd10);
    for (int k = 0; k < 300; k++) wr(32'h400, 32'hEE);
    check("drop_cnt sat", 32'(drop_cnt), 32'h0000_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, 2..16.
REQ-003 SHALL have parameter BASE_ADR, default 32'h0000_0400: TXDATA register address; STATUS register is at BASE_ADR+4.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port MemWrite, input, 1: store strobe from riscv_cpu_main.
REQ-007 SHALL have port DataAdr, input, 32: store/load address from riscv_cpu_main.
REQ-008 SHALL have port WriteData, input, 32: store data from riscv_cpu_main; only bits [7:0] are used.
REQ-009 SHALL have port ReadData, output, 32: STATUS value when DataAdr==BASE_ADR+4, else 0; combinational.
REQ-010 SHALL have port Hit, output, 1: high when DataAdr equals BASE_ADR or BASE_ADR+4; combinational.
REQ-011 SHALL have port tx, output, 1: serial line, idle high, driven from a register.
REQ-012 SHALL have port drop_cnt, output, 8: count of TXDATA writes discarded because the FIFO was full.

Function
REQ-013 SHALL push WriteData[7:0] into the FIFO on a rising edge where MemWrite=1, DataAdr==BASE_ADR and the FIFO is not full.
REQ-014 SHALL ignore writes to BASE_ADR+4 and to every other address.
REQ-015 SHALL evaluate "full" on the count before the edge: a write to a full FIFO is dropped even if a pop occurs on the same edge.
REQ-016 SHALL increment drop_cnt on each dropped write and saturate at 8'hFF.
REQ-017 SHALL accept a simultaneous push and pop on a non-full FIFO and leave the count unchanged.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1; on an edge with the FIFO non-empty, pop the head byte into a shift register and go to START.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-021 DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit index wraps 7->0 on exit to STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-023 SHALL have a frame length of exactly 10*CLKS_PER_BIT cycles.
REQ-024 SHALL drop tx low on the edge after the push edge when the FSM is IDLE and the FIFO was empty (1-cycle latency).
REQ-025 SHALL allow back-to-back frames: when the FIFO is non-empty, the STOP->IDLE edge is followed by IDLE->START on the next edge (one idle-high cycle).
REQ-026 SHALL format STATUS as: bit0 busy (state!=IDLE), bit1 fifo_full, bit2 fifo_empty, bits[7:3]=0, bits[12:8] fifo count, bits[31:13]=0.
REQ-027 SHALL use a bit-timer that counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.

Reset
REQ-028 SHALL, on a reset edge: FSM=IDLE, tx=1, FIFO empty (pointers and count 0), bit-timer=0, bit index=0, drop_cnt=0.
REQ-029 SHALL let reset asserted mid-frame abort the frame immediately: tx=1 after that edge, and queued bytes are discarded.
REQ-030 SHALL give reset priority over a concurrent write: nothing is pushed on a reset edge.

Structure
REQ-031 SHALL place the FSM state enum, the STATUS bit positions and the TXDATA/STATUS offsets in package uart_mmio_pkg.
REQ-032 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk, reset, push, pop, din, dout, full, empty, count).

Verification
REQ-033 SHALL cover: CLKS_PER_BIT=4, write 8'h55 to 0x400 -> tx low 1 cycle after the push edge, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high, 40-cycle frame, STATUS=32'h0000_0004 afterwards.
REQ-034 SHALL cover: FIFO_DEPTH=4, six consecutive writes 0x01..0x06 while busy -> first pops immediately, 4 queued, 6th dropped, drop_cnt=1, serial output 01,02,03,04,05.
REQ-035 SHALL cover: write with WriteData=32'hDEAD_BEA5 -> transmitted byte A5; a write to 0x404 and a write to 0x408 -> no push, count unchanged.
REQ-036 SHALL cover: reset asserted in DATA bit 3 -> tx=1 on the next edge, STATUS=32'h0000_0004, drop_cnt=0, no further frames.
REQ-037 SHALL cover: push on the same edge as a pop with count=2 -> count remains 2; push when full on a pop edge -> dropped, count 3.
REQ-038 SHALL cover: 300 writes to a full FIFO -> drop_cnt saturates at 8'hFF.
